// File: rtl/prog_seq_pkg.sv
// prog_seq_pkg: shared definitions for the program sequencer.
//   - state encodings (legacy 3-bit constants plus a typed enum over them)
//   - opcode constants of the four-instruction core
//   - default geometry and watchdog limit
//   - small helper functions used by the sequencer datapath
package prog_seq_pkg;

  // Legacy-compatible state codes; the enum below is built on these values.
  localparam logic [2:0] ST_IDLE     = 3'd0;
  localparam logic [2:0] ST_FETCH    = 3'd1;
  localparam logic [2:0] ST_ISSUE    = 3'd2;
  localparam logic [2:0] ST_EXEC     = 3'd3;
  localparam logic [2:0] ST_FINISHED = 3'd4;
  localparam logic [2:0] ST_FAULT    = 3'd5;

  typedef enum logic [2:0] {
    IDLE     = ST_IDLE,
    FETCH    = ST_FETCH,
    ISSUE    = ST_ISSUE,
    EXEC     = ST_EXEC,
    FINISHED = ST_FINISHED,
    FAULT    = ST_FAULT
  } state_e;

  // Core opcodes, found in instruction bits [2:0].
  localparam logic [2:0] MV  = 3'b000;
  localparam logic [2:0] MVI = 3'b001;
  localparam logic [2:0] ADD = 3'b010;
  localparam logic [2:0] SUB = 3'b011;

  localparam int AW_DEFAULT   = 5;
  localparam int WDOG_DEFAULT = 4;

  // Saturating increment for the 8-bit instruction counter.
  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  // Only opcodes with bit 2 clear exist in the core.
  function automatic logic op_is_legal(input logic [2:0] op);
    return (op[2] == 1'b0);
  endfunction

  // States in which the sequencer owns an instruction in flight.
  function automatic logic state_is_busy(input state_e s);
    return (s == FETCH) || (s == ISSUE) || (s == EXEC);
  endfunction

endpackage

// File: rtl/prog_sequencer_watchdog.sv
// exec_watchdog: clear/enable cycle counter guarding the EXEC phase.
//   Clock, Resetn : system clock, asynchronous active-low reset
//   clear         : restart the count (asserted while issuing an instruction)
//   enable        : count this cycle (asserted in every EXEC cycle)
//   first_cycle   : count is zero, i.e. this is the first EXEC cycle
//   expired       : this enabled cycle is the WDOG-th one; without Done the
//                   sequencer must fault at the closing edge
module exec_watchdog
  import prog_seq_pkg::*;
#(
  parameter int WDOG = WDOG_DEFAULT
) (
  input  logic Clock,
  input  logic Resetn,
  input  logic clear,
  input  logic enable,
  output logic first_cycle,
  output logic expired
);

  localparam int CW = $clog2(WDOG + 1);
  localparam logic [CW-1:0] CNT_ZERO = {CW{1'b0}};
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);
  localparam logic [CW-1:0] CNT_MAX  = CW'(WDOG);
  localparam logic [CW-1:0] CNT_LAST = CW'(WDOG - 1);

  logic [CW-1:0] count_r;

  // Count enabled cycles since the last clear, holding at WDOG.
  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      count_r <= CNT_ZERO;
    end else if (clear) begin
      count_r <= CNT_ZERO;
    end else if (enable && (count_r != CNT_MAX)) begin
      count_r <= count_r + CNT_ONE;
    end else begin
      count_r <= count_r;
    end
  end

  assign first_cycle = (count_r == CNT_ZERO);
  assign expired     = enable && (count_r == CNT_LAST);

endmodule

// File: rtl/prog_sequencer.sv
// prog_sequencer: fetches 9-bit instructions from a synchronous-read program
// memory and issues them to the mv/mvi/add/sub core.
//   Clock, Resetn        : system clock and async active-low reset (shared with core)
//   Start, Stop          : control pulses
//   StartAddr, EndAddr   : first and last (inclusive) program address
//   Mem_rd, Mem_addr     : memory read strobe/address; Mem_data arrives next cycle
//   DIN, Run, Done       : core instruction/immediate bus, issue pulse, completion
//   PC, InstrCount       : current/next instruction address, completed count
//   Busy, Finished, Error: status levels
// Mem_rd/Mem_addr/DIN/Run are decoded from the state register in the same
// cycle: Run and DIN must carry the word that the memory returns in ISSUE, so
// they cannot take an extra register stage. Status outputs are registered.
module prog_sequencer
  import prog_seq_pkg::*;
#(
  parameter int AW   = AW_DEFAULT,
  parameter int WDOG = WDOG_DEFAULT
) (
  input  logic          Clock,
  input  logic          Resetn,
  input  logic          Start,
  input  logic          Stop,
  input  logic [AW-1:0] StartAddr,
  input  logic [AW-1:0] EndAddr,
  output logic          Mem_rd,
  output logic [AW-1:0] Mem_addr,
  input  logic [8:0]    Mem_data,
  output logic [8:0]    DIN,
  output logic          Run,
  input  logic          Done,
  output logic [AW-1:0] PC,
  output logic [7:0]    InstrCount,
  output logic          Busy,
  output logic          Finished,
  output logic          Error
);

  localparam logic [AW-1:0] PC_ZERO = {AW{1'b0}};
  localparam logic [AW-1:0] PC_ONE  = AW'(1);
  localparam logic [AW-1:0] PC_TWO  = AW'(2);

  state_e        state_r, state_nxt_s;
  logic [AW-1:0] pc_r, pc_nxt_s;
  logic [7:0]    icnt_r, icnt_nxt_s;
  // Only the opcode field of the issued word is needed after ISSUE.
  logic [2:0]    ir_op_r, ir_op_nxt_s;
  logic          stop_pend_r;
  logic          busy_r, fin_r, err_r;

  logic          mem_rd_s;
  logic [AW-1:0] mem_addr_s;
  logic [8:0]    din_s;
  logic          run_s;
  logic          wd_clear_s, wd_en_s, wd_first_s, wd_expired_s;

  logic [2:0]    issue_op_s;
  logic          ir_is_mvi_s;
  logic [AW-1:0] step_s;
  logic [AW-1:0] last_addr_s;
  logic          busy_now_s;

  assign issue_op_s  = Mem_data[2:0];
  assign ir_is_mvi_s = (ir_op_r == MVI);
  // An mvi occupies two words: advance by two, and its last word is PC+1.
  assign step_s      = ir_is_mvi_s ? PC_TWO : PC_ONE;
  assign last_addr_s = ir_is_mvi_s ? (pc_r + PC_ONE) : pc_r;
  assign busy_now_s  = state_is_busy(state_r);

  exec_watchdog #(
    .WDOG(WDOG)
  ) u_wdog (
    .Clock      (Clock),
    .Resetn     (Resetn),
    .clear      (wd_clear_s),
    .enable     (wd_en_s),
    .first_cycle(wd_first_s),
    .expired    (wd_expired_s)
  );

  // Next-state, datapath updates and per-state core/memory strobes.
  always_comb begin
    state_nxt_s = state_r;
    pc_nxt_s    = pc_r;
    icnt_nxt_s  = icnt_r;
    ir_op_nxt_s = ir_op_r;
    mem_rd_s    = 1'b0;
    mem_addr_s  = PC_ZERO;
    din_s       = 9'd0;
    run_s       = 1'b0;
    wd_clear_s  = 1'b0;
    wd_en_s     = 1'b0;

    case (state_r)
      IDLE, FINISHED, FAULT: begin
        if (Start) begin
          state_nxt_s = FETCH;
          pc_nxt_s    = StartAddr;
          icnt_nxt_s  = 8'd0;
        end else begin
          state_nxt_s = state_r;
        end
      end

      FETCH: begin
        mem_rd_s   = 1'b1;
        mem_addr_s = pc_r;
        if (stop_pend_r) begin
          state_nxt_s = IDLE;
        end else begin
          state_nxt_s = ISSUE;
        end
      end

      ISSUE: begin
        ir_op_nxt_s = issue_op_s;
        if (stop_pend_r) begin
          state_nxt_s = IDLE;
        end else if (!op_is_legal(issue_op_s)) begin
          state_nxt_s = FAULT;
        end else if ((issue_op_s == MVI) && (pc_r == EndAddr)) begin
          // The immediate would sit past the end of the program.
          state_nxt_s = FAULT;
        end else begin
          run_s       = 1'b1;
          din_s       = Mem_data;
          wd_clear_s  = 1'b1;
          state_nxt_s = EXEC;
          if (issue_op_s == MVI) begin
            // Prefetch the immediate so it lands on DIN in the core's T1.
            mem_rd_s   = 1'b1;
            mem_addr_s = pc_r + PC_ONE;
          end else begin
            mem_rd_s = 1'b0;
          end
        end
      end

      EXEC: begin
        wd_en_s = 1'b1;
        if (ir_is_mvi_s && wd_first_s) begin
          din_s = Mem_data;
        end else begin
          din_s = 9'd0;
        end
        if (Done) begin
          pc_nxt_s   = pc_r + step_s;
          icnt_nxt_s = sat_inc8(icnt_r);
          if (stop_pend_r) begin
            state_nxt_s = IDLE;
          end else if (last_addr_s == EndAddr) begin
            state_nxt_s = FINISHED;
          end else begin
            state_nxt_s = FETCH;
          end
        end else if (wd_expired_s) begin
          state_nxt_s = FAULT;
        end else begin
          state_nxt_s = EXEC;
        end
      end

      default: begin
        state_nxt_s = IDLE;
      end
    endcase
  end

  // Main state and datapath registers.
  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      state_r <= IDLE;
      pc_r    <= PC_ZERO;
      icnt_r  <= 8'd0;
      ir_op_r <= 3'd0;
    end else begin
      state_r <= state_nxt_s;
      pc_r    <= pc_nxt_s;
      icnt_r  <= icnt_nxt_s;
      ir_op_r <= ir_op_nxt_s;
    end
  end

  // Stop is remembered only while busy; it is dropped once acted on or when
  // the block is not running (so a Stop coinciding with Start is lost).
  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      stop_pend_r <= 1'b0;
    end else if (!busy_now_s) begin
      stop_pend_r <= 1'b0;
    end else if (state_nxt_s == IDLE) begin
      stop_pend_r <= 1'b0;
    end else if (Stop) begin
      stop_pend_r <= 1'b1;
    end else begin
      stop_pend_r <= stop_pend_r;
    end
  end

  // Registered status levels, computed from the state being entered.
  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      busy_r <= 1'b0;
      fin_r  <= 1'b0;
      err_r  <= 1'b0;
    end else begin
      busy_r <= state_is_busy(state_nxt_s);
      fin_r  <= (state_nxt_s == FINISHED);
      err_r  <= (state_nxt_s == FAULT);
    end
  end

  assign Mem_rd     = mem_rd_s;
  assign Mem_addr   = mem_addr_s;
  assign DIN        = din_s;
  assign Run        = run_s;
  assign PC         = pc_r;
  assign InstrCount = icnt_r;
  assign Busy       = busy_r;
  assign Finished   = fin_r;
  assign Error      = err_r;

endmodule

// File: tb/tb_prog_sequencer.sv
// Self-checking bench for prog_sequencer: behavioural core + memory, a
// program-level reference model, directed scenarios and randomized programs.
module tb_prog_sequencer;

  localparam int AW   = 5;
  localparam int WDOG = 4;

  logic          Clock = 1'b0;
  logic          Resetn = 1'b0;
  logic          Start = 1'b0;
  logic          Stop = 1'b0;
  logic [AW-1:0] StartAddr = 5'd0;
  logic [AW-1:0] EndAddr = 5'd0;
  logic          Mem_rd;
  logic [AW-1:0] Mem_addr;
  logic [8:0]    Mem_data = 9'd0;
  logic [8:0]    DIN;
  logic          Run;
  logic          Done;
  logic [AW-1:0] PC;
  logic [7:0]    InstrCount;
  logic          Busy, Finished, Error;

  prog_sequencer #(.AW(AW), .WDOG(WDOG)) dut (
    .Clock(Clock), .Resetn(Resetn), .Start(Start), .Stop(Stop),
    .StartAddr(StartAddr), .EndAddr(EndAddr),
    .Mem_rd(Mem_rd), .Mem_addr(Mem_addr), .Mem_data(Mem_data),
    .DIN(DIN), .Run(Run), .Done(Done),
    .PC(PC), .InstrCount(InstrCount),
    .Busy(Busy), .Finished(Finished), .Error(Error)
  );

  always #5 Clock = ~Clock;

  // Program memory: synchronous read; garbage when not strobed.
  logic [8:0] mem [0:31];
  always @(posedge Clock) begin
    if (Mem_rd) Mem_data <= mem[Mem_addr];
    else        Mem_data <= 9'($urandom);
  end

  // Behavioural core: word = {Y[8:6], X[5:3], op[2:0]}.
  logic [8:0] creg [0:7];
  logic [1:0] ct;
  logic [8:0] cir, ca, cg;
  logic       hang = 1'b0;
  always @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      ct <= 2'd0; cir <= 9'd0; ca <= 9'd0; cg <= 9'd0;
      for (int i = 0; i < 8; i++) creg[i] <= 9'd0;
    end else begin
      case (ct)
        2'd0: if (Run) begin cir <= DIN; ct <= 2'd1; end
        2'd1: begin
          if (hang) ct <= 2'd1;
          else case (cir[2:0])
            3'd0: begin creg[cir[5:3]] <= creg[cir[8:6]]; ct <= 2'd0; end
            3'd1: begin creg[cir[5:3]] <= DIN; ct <= 2'd0; end
            3'd2, 3'd3: begin ca <= creg[cir[5:3]]; ct <= 2'd2; end
            default: ct <= 2'd0;
          endcase
        end
        2'd2: begin cg <= cir[0] ? ca - creg[cir[8:6]] : ca + creg[cir[8:6]]; ct <= 2'd3; end
        default: begin creg[cir[5:3]] <= cg; ct <= 2'd0; end
      endcase
    end
  end
  assign Done = !hang && (((ct == 2'd1) && (cir[2:1] == 2'b00)) || (ct == 2'd3));

  // Protocol monitor: Run count, Run only in core T0, Run one cycle wide.
  int         run_cnt = 0;
  int         viol = 0;
  logic       run_prev = 1'b0;
  logic [8:0] din_after = 9'd0;
  always @(negedge Clock) begin
    if (run_prev) din_after = DIN;
    if (Run) begin
      run_cnt++;
      if (ct != 2'd0) viol++;
      if (run_prev) viol++;
    end
    run_prev = Run;
  end

  int checks = 0;
  int failures = 0;

  task automatic check_eq(input string tag, input logic [71:0] got, input logic [71:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Reference model results.
  logic [4:0]  e_pc;
  logic [7:0]  e_cnt;
  logic        e_fin, e_err;
  int          e_cyc, e_runs;
  logic [71:0] e_regs;
  int          last_cyc, last_runs;

  // Walks the program instruction by instruction. Each instruction occupies
  // FETCH+ISSUE plus 1 (mv/mvi) or 3 (add/sub) EXEC cycles; a Stop pulsed in
  // busy cycle k takes effect from cycle k+1.
  task automatic model_run(input logic [4:0] sa, input logic [4:0] ea, input int stop_k, input bit hng);
    logic [8:0] r [8];
    logic [4:0] pc, last;
    logic [8:0] w;
    logic [2:0] op, x, y;
    int s, len;
    bit fin_flag;
    for (int i = 0; i < 8; i++) r[i] = 9'd0;
    pc = sa; e_cnt = 8'd0; e_fin = 1'b0; e_err = 1'b0; e_runs = 0; e_cyc = 0;
    s = 0; fin_flag = 1'b0;
    for (int it = 0; it < 200 && !fin_flag; it++) begin
      if (stop_k < s) begin e_cyc = s + 1; fin_flag = 1'b1; end
      else if (stop_k == s) begin e_cyc = s + 2; fin_flag = 1'b1; end
      else begin
        w = mem[pc]; op = w[2:0]; x = w[5:3]; y = w[8:6];
        if (op > 3'd3 || (op == 3'd1 && pc == ea)) begin
          e_err = 1'b1; e_cyc = s + 2; fin_flag = 1'b1;
        end else if (hng) begin
          e_runs++; e_err = 1'b1; e_cyc = s + 2 + WDOG; fin_flag = 1'b1;
        end else begin
          e_runs++;
          len = (op <= 3'd1) ? 3 : 5;
          case (op)
            3'd0: r[x] = r[y];
            3'd1: r[x] = mem[pc + 5'd1];
            3'd2: r[x] = r[x] + r[y];
            default: r[x] = r[x] - r[y];
          endcase
          last = (op == 3'd1) ? pc + 5'd1 : pc;
          pc = last + 5'd1;
          if (e_cnt != 8'd255) e_cnt++;
          if (stop_k >= s + 1 && stop_k <= s + len - 2) begin e_cyc = s + len; fin_flag = 1'b1; end
          else if (last == ea) begin e_fin = 1'b1; e_cyc = s + len; fin_flag = 1'b1; end
          else s += len;
        end
      end
    end
    e_pc = pc;
    e_regs = {r[7], r[6], r[5], r[4], r[3], r[2], r[1], r[0]};
  endtask

  // Reset, start a program, drive Stop in busy cycle stop_k, compare to model.
  task automatic run_prog(input logic [4:0] sa, input logic [4:0] ea, input int stop_k,
                          input bit hng, input string tag);
    int c, r0;
    bit ended;
    Resetn = 1'b0;
    hang = hng;
    @(posedge Clock); #1;
    Resetn = 1'b1;
    @(posedge Clock); #1;
    r0 = run_cnt;
    StartAddr = sa; EndAddr = ea; Start = 1'b1;
    @(posedge Clock); #1;
    Start = 1'b0;
    c = 0; ended = 1'b0;
    while (!ended && c < 400) begin
      if (!Busy) ended = 1'b1;
      else begin
        Stop = (c == stop_k);
        @(posedge Clock); #1;
        c++;
      end
    end
    Stop = 1'b0;
    last_cyc = c;
    last_runs = run_cnt - r0;
    model_run(sa, ea, stop_k, hng);
    check_eq({tag, ".term"}, ended, 1'b1);
    check_eq({tag, ".cycles"}, c, e_cyc);
    check_eq({tag, ".pc"}, PC, e_pc);
    check_eq({tag, ".cnt"}, InstrCount, e_cnt);
    check_eq({tag, ".fin"}, Finished, e_fin);
    check_eq({tag, ".err"}, Error, e_err);
    check_eq({tag, ".runs"}, last_runs, e_runs);
    check_eq({tag, ".regs"}, {creg[7], creg[6], creg[5], creg[4], creg[3], creg[2], creg[1], creg[0]}, e_regs);
    check_eq({tag, ".proto"}, viol, 0);
  endtask

  function automatic logic [8:0] enc(input logic [2:0] op, input logic [2:0] x, input logic [2:0] y);
    return {y, x, op};
  endfunction

  initial begin
    int stop_k, r0;
    logic [4:0] sa, ea;
    for (int i = 0; i < 32; i++) mem[i] = 9'd0;

    // Reset state.
    Resetn = 1'b0;
    repeat (2) @(posedge Clock);
    #1;
    check_eq("reset.outs", {Mem_rd, Mem_addr, DIN, Run, PC, InstrCount, Busy, Finished, Error}, 36'd0);

    // Single mvi R0,#5 ending at 1.
    mem[0] = enc(3'b001, 3'd0, 3'd0); mem[1] = 9'd5;
    run_prog(5'd0, 5'd1, 100000, 1'b0, "mvi1");
    check_eq("mvi1.din_t1", din_after, 9'd5);
    check_eq("mvi1.r0", creg[0], 9'd5);
    check_eq("mvi1.pc2", PC, 5'd2);
    check_eq("mvi1.runs1", last_runs, 1);

    // mvi R0,#3; mvi R1,#4; add R0,R1.
    mem[0] = enc(3'b001, 3'd0, 3'd0); mem[1] = 9'd3;
    mem[2] = enc(3'b001, 3'd1, 3'd0); mem[3] = 9'd4;
    mem[4] = enc(3'b010, 3'd0, 3'd1);
    run_prog(5'd0, 5'd4, 100000, 1'b0, "add3");
    check_eq("add3.r0", creg[0], 9'd7);
    check_eq("add3.cnt3", InstrCount, 8'd3);
    check_eq("add3.cyc11", last_cyc, 11);

    // Illegal opcode at StartAddr.
    mem[3] = 9'b000_000_110;
    run_prog(5'd3, 5'd6, 100000, 1'b0, "badop");
    check_eq("badop.err1", Error, 1'b1);
    check_eq("badop.norun", last_runs, 0);
    check_eq("badop.pc", PC, 5'd3);

    // mvi at EndAddr.
    mem[7] = enc(3'b001, 3'd2, 3'd0);
    run_prog(5'd7, 5'd7, 100000, 1'b0, "mviend");
    check_eq("mviend.err1", Error, 1'b1);
    check_eq("mviend.norun", last_runs, 0);

    // Core never answers: watchdog fault after WDOG EXEC cycles.
    mem[0] = enc(3'b000, 3'd1, 3'd0);
    run_prog(5'd0, 5'd3, 100000, 1'b1, "wdog");
    check_eq("wdog.err1", Error, 1'b1);
    check_eq("wdog.cyc", last_cyc, 2 + WDOG);

    // Stop during add's EXEC: mvi R1,#6 (0..1), add R0,R1 (2), mv R2,R0 (3).
    mem[0] = enc(3'b001, 3'd1, 3'd0); mem[1] = 9'd6;
    mem[2] = enc(3'b010, 3'd0, 3'd1);
    mem[3] = enc(3'b000, 3'd2, 3'd0);
    run_prog(5'd0, 5'd4, 5, 1'b0, "stop");
    check_eq("stop.busy0", Busy, 1'b0);
    check_eq("stop.cnt2", InstrCount, 8'd2);
    check_eq("stop.r0", creg[0], 9'd6);
    r0 = run_cnt;
    repeat (6) @(posedge Clock);
    #1;
    check_eq("stop.quiet", run_cnt - r0, 0);

    // Asynchronous reset in the middle of FETCH.
    StartAddr = 5'd3; Start = 1'b1;
    @(posedge Clock); #1;
    Start = 1'b0;
    check_eq("arst.fetch", {Mem_rd, PC}, {1'b1, 5'd3});
    #2 Resetn = 1'b0;
    #1;
    check_eq("arst.outs", {Mem_rd, Mem_addr, DIN, Run, PC, InstrCount, Busy, Finished, Error}, 36'd0);
    #2 Resetn = 1'b1;

    // Randomized programs, some with a Stop pulse or a hung core.
    for (int n = 0; n < 25; n++) begin
      for (int i = 0; i < 32; i++) begin
        if ($urandom_range(0, 15) == 0)
          mem[i] = {9'($urandom)} & 9'h1F8 | 9'($urandom_range(4, 7));
        else
          mem[i] = {3'($urandom), 3'($urandom), 3'($urandom_range(0, 3))};
      end
      sa = 5'($urandom);
      ea = sa + 5'($urandom_range(0, 12));
      stop_k = ($urandom_range(0, 2) == 0) ? int'($urandom_range(0, 25)) : 100000;
      run_prog(sa, ea, stop_k, ($urandom_range(0, 7) == 0), $sformatf("rnd%0d", n));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
